// File: rtl/s2_pkg.sv
// Shared constants and state type for the RB2 serial frame receiver.
package s2_pkg;
  localparam int ADDR_W     = 3;
  localparam int DATA_W     = 18;
  localparam int FRAMES     = 8;
  localparam int FRAME_BITS = ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DONE
  } s2_state_t;
endpackage

// File: rtl/sipo_shifter.sv
// Serial-in/parallel-out frame register with a saturating 5-bit bit counter.
module sipo_shifter #(
  parameter int WIDTH = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             clear,
  input  logic             sd,
  output logic [WIDTH-1:0] shift_q,
  output logic [4:0]       bitcnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      bitcnt  <= '0;
    end else if (clear) begin
      shift_q <= '0;
      bitcnt  <= '0;
    end else if (shift_en) begin
      // Overlong frames naturally keep only the last WIDTH bits.
      shift_q <= {shift_q[WIDTH-2:0], sd};
      if (bitcnt != 5'd31)
        bitcnt <= bitcnt + 5'd1;
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Deserialises sen/sd frames (address then data, MSB first) into RB2 write pulses.
// Optional length check and sticky frame_err port: define S2_FRAME_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for sen=0; first low sample shifts in the first bit
// RECV  | shifting bits; sen=1 ends the frame and triggers the RB2 write
// DONE  | FRAMES frames written; S2_done held, link ignored until reset
module serial_frame_rx
  import s2_pkg::*;
#(
  parameter int ADDR_W = s2_pkg::ADDR_W,
  parameter int DATA_W = s2_pkg::DATA_W,
  parameter int FRAMES = s2_pkg::FRAMES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sen,
  input  logic              sd,
  output logic              RB2_RW,
  output logic [ADDR_W-1:0] RB2_A,
  output logic [DATA_W-1:0] RB2_D,
  output logic              S2_done
`ifdef S2_FRAME_CHECK_EN
  , output logic            frame_err
`endif
);

  localparam int NBITS = ADDR_W + DATA_W;
  localparam int FCW   = $clog2(FRAMES + 1);

  s2_state_t        state;
  logic [FCW-1:0]   frcnt;
  logic [NBITS-1:0] shift_q;
  logic [4:0]       bitcnt;
  logic             shift_en;
  logic             clear;
  logic             accept;

  assign shift_en = !sen && (state == IDLE || state == RECV);
  assign clear    = sen && (state == RECV);

`ifdef S2_FRAME_CHECK_EN
  assign accept = (bitcnt == 5'(NBITS));
`else
  assign accept = (bitcnt != 5'd0);
`endif

  sipo_shifter #(.WIDTH(NBITS)) u_sipo (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .clear    (clear),
    .sd       (sd),
    .shift_q  (shift_q),
    .bitcnt   (bitcnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      frcnt     <= '0;
      RB2_RW    <= 1'b1;
      RB2_A     <= '0;
      RB2_D     <= '0;
      S2_done   <= 1'b0;
`ifdef S2_FRAME_CHECK_EN
      frame_err <= 1'b0;
`endif
    end else begin
      // Write strobe is a single-cycle pulse; the default re-arms it.
      RB2_RW <= 1'b1;
      case (state)
        IDLE: begin
          if (!sen)
            state <= RECV;
        end
        RECV: begin
          if (sen) begin
            if (accept) begin
              RB2_A  <= shift_q[NBITS-1:DATA_W];
              RB2_D  <= shift_q[DATA_W-1:0];
              RB2_RW <= 1'b0;
              frcnt  <= frcnt + 1'b1;
              state  <= (frcnt == FCW'(FRAMES - 1)) ? DONE : IDLE;
            end else begin
`ifdef S2_FRAME_CHECK_EN
              frame_err <= 1'b1;
`endif
              state <= IDLE;
            end
          end
        end
        DONE: begin
          S2_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx: random frames vs. a bit-list reference model.
module tb_serial_frame_rx;

  localparam int AW = 3;
  localparam int DW = 18;
  localparam int NB = AW + DW;
  localparam int NF = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          sen;
  logic          sd;
  logic          RB2_RW;
  logic [AW-1:0] RB2_A;
  logic [DW-1:0] RB2_D;
  logic          S2_done;
`ifdef S2_FRAME_CHECK_EN
  logic          frame_err;
`endif

  int checks = 0;
  int errors = 0;
  logic [NB-1:0] exp_q[$];
  int model_frames = 0;

  always #5 clk = ~clk;

  serial_frame_rx #(.ADDR_W(AW), .DATA_W(DW), .FRAMES(NF)) dut (
    .clk       (clk),
    .rst       (rst),
    .sen       (sen),
    .sd        (sd),
    .RB2_RW    (RB2_RW),
    .RB2_A     (RB2_A),
    .RB2_D     (RB2_D),
    .S2_done   (S2_done)
`ifdef S2_FRAME_CHECK_EN
    , .frame_err (frame_err)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: a frame is the list of bits seen while sen is low; the write
  // carries the last NB of them (zero-filled on the left when short).
  task automatic send_frame(input logic [31:0] word, input int len);
    logic [NB-1:0] v;
    bit ok;
    v = '0;
    for (int i = len - 1; i >= 0; i--) begin
      @(negedge clk);
      sen = 1'b0;
      sd  = word[i];
      v   = {v[NB-2:0], word[i]};
    end
    @(negedge clk);
    sen = 1'b1;
    sd  = 1'($urandom);
`ifdef S2_FRAME_CHECK_EN
    ok = (len == NB);
`else
    ok = (len >= 1);
`endif
    if (ok && model_frames < NF) begin
      exp_q.push_back(v);
      model_frames++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sen = 1'b1;
    end
  endtask

  // Monitor: every write pulse must match the oldest expected frame.
  initial begin
    int writes;
    bit done_due;
    logic [NB-1:0] e;
    writes = 0;
    done_due = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        writes = 0;
        done_due = 0;
      end else begin
        if (done_due)
          check("done_rise", 32'(S2_done), 32'd1);
        done_due = 0;
        if (RB2_RW == 1'b0) begin
          check("done_early", 32'(S2_done), 32'd0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual A=%0h D=%0h expected no write", RB2_A, RB2_D);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", 32'(RB2_A), 32'(e[NB-1:DW]));
            check("wr_data", 32'(RB2_D), 32'(e[DW-1:0]));
          end
          writes++;
          if (writes == NF)
            done_due = 1;
        end
      end
    end
  end

  initial begin
    logic [31:0] w;
    rst = 1'b0;
    sen = 1'b1;
    sd  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rw", 32'(RB2_RW), 32'd1);
    check("rst_a", 32'(RB2_A), 32'd0);
    check("rst_d", 32'(RB2_D), 32'd0);
    check("rst_done", 32'(S2_done), 32'd0);
`ifdef S2_FRAME_CHECK_EN
    check("rst_err", 32'(frame_err), 32'd0);
`endif
    rst = 1'b1;
    idle(2);

    send_frame({11'd0, 3'b101, 18'h2A5C3}, NB);
    idle(3);

    // Back-to-back: the single gap cycle is also the write trigger.
    send_frame({11'd0, 3'd1, 18'($urandom)}, NB);
    send_frame({11'd0, 3'd2, 18'h3FFFF}, NB);
    idle(3);

    send_frame(32'($urandom_range(0, 1023)), 10);
    idle(3);
`ifdef S2_FRAME_CHECK_EN
    check("err_short", 32'(frame_err), 32'd1);
`endif
    send_frame({11'd0, 3'($urandom), 18'($urandom)}, NB);
    idle(3);
`ifdef S2_FRAME_CHECK_EN
    check("err_sticky", 32'(frame_err), 32'd1);
`endif

    for (int k = 0; k < 3; k++) begin
      send_frame($urandom, $urandom_range(15, 28));
    end
    idle(3);

    // Reset mid-frame after 12 bits; the partial frame is discarded.
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      sen = 1'b0;
      sd  = 1'($urandom);
    end
    @(negedge clk);
    rst = 1'b0;
    sen = 1'b1;
    model_frames = 0;
    #1;
    check("mid_rst_rw", 32'(RB2_RW), 32'd1);
    check("mid_rst_a", 32'(RB2_A), 32'd0);
    check("mid_rst_d", 32'(RB2_D), 32'd0);
    check("mid_rst_done", 32'(S2_done), 32'd0);
`ifdef S2_FRAME_CHECK_EN
    check("mid_rst_err", 32'(frame_err), 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(2);

    for (int a = 0; a < NF; a++) begin
      w = (32'(a) << DW) | (32'd1 << a);
      send_frame(w, NB);
    end
    idle(4);
    check("done_set", 32'(S2_done), 32'd1);

    send_frame({11'd0, 3'($urandom), 18'($urandom)}, NB);
    idle(4);
    check("done_hold", 32'(S2_done), 32'd1);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_writes actual pending=%0d expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
